// File: rtl/serial_sum_collector.sv
// serial_sum_collector
//
// Downstream stage of the bit-serial adder. Assembles the LSB-first serial
// sum bit `s` into WORD_W-bit words, captures the carry `c` on each word's
// last bit as the word's carry-out, and queues completed words in a
// 2-entry in-order FIFO behind a valid/ready handshake.
//
// Parameters:
//   WORD_W    bits per serial word (>= 2)
//   CNT_W     width of the completed-word counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   s/c carry a valid bit this cycle
//   s          serial sum bit, LSB first
//   c          adder carry; sampled only on a word's last bit
//   out_ready  consumer accepts the FIFO head
//   out_valid  FIFO non-empty
//   out_sum    FIFO head sum word
//   out_cout   FIFO head carry-out
//   word_cnt   words pushed since reset, wraps modulo 2^CNT_W
//   err_drop   sticky: a completed word was dropped on a full FIFO
//
// All outputs come straight from registers; there is no combinational
// path from any input to any output.

module serial_sum_collector #(
    parameter int WORD_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              s,
    input  logic              c,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_cout,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              err_drop
);

    localparam int BCNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

    // Bit position of the next incoming bit within the current word.
    logic [BCNT_W-1:0] bcnt;
    // Bits received so far; the oldest bit sits at index 0. Only WORD_W-1
    // bits are stored: the last bit goes straight from `s` into the word.
    logic [WORD_W-2:0] shreg;

    // FIFO as a head/tail register pair so the head is always a plain
    // register and simply holds its value once the FIFO drains.
    logic [1:0]        fill;
    logic [WORD_W-1:0] head_sum;
    logic              head_cout;
    logic [WORD_W-1:0] tail_sum;
    logic              tail_cout;

    logic [WORD_W-1:0] new_word;
    logic              last_bit;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign new_word = {s, shreg};

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        last_bit = 1'b0;
        pop      = 1'b0;
        push_ok  = 1'b0;
        drop     = 1'b0;

        last_bit = in_valid && (bcnt == LAST_BIT);
        pop      = (fill != 2'd0) && out_ready;
        // A completing word fits if the FIFO is not full, or if the head
        // leaves on the same edge.
        push_ok  = last_bit && ((fill != 2'd2) || pop);
        drop     = last_bit && !push_ok;
    end

    // Serial deserializer: frozen while in_valid is low, so gaps are free.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            shreg <= '0;
        end else if (in_valid) begin
            shreg <= new_word[WORD_W-1:1];
            bcnt  <= last_bit ? '0 : bcnt + 1'b1;
        end
    end

    // FIFO, word counter and sticky drop flag.
    // NOTE: the data registers are reset as well because they drive out_sum
    // and out_cout directly, which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= 2'd0;
            head_sum  <= '0;
            head_cout <= 1'b0;
            tail_sum  <= '0;
            tail_cout <= 1'b0;
            word_cnt  <= '0;
            err_drop  <= 1'b0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (fill == 2'd0) begin
                        head_sum  <= new_word;
                        head_cout <= c;
                    end else begin
                        tail_sum  <= new_word;
                        tail_cout <= c;
                    end
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves the head holding its
                    // stale value.
                    if (fill == 2'd2) begin
                        head_sum  <= tail_sum;
                        head_cout <= tail_cout;
                    end
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind
                    // whatever remains after the pop.
                    if (fill == 2'd1) begin
                        head_sum  <= new_word;
                        head_cout <= c;
                    end else begin
                        head_sum  <= tail_sum;
                        head_cout <= tail_cout;
                        tail_sum  <= new_word;
                        tail_cout <= c;
                    end
                end
                default: ;
            endcase

            if (push_ok) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (drop) begin
                err_drop <= 1'b1;
            end
        end
    end

    assign out_valid = (fill != 2'd0);
    assign out_sum   = head_sum;
    assign out_cout  = head_cout;

endmodule
